udp_tx_pkt_buffer: RTL and testbench

//  Packet store-and-forward buffer that feeds eth_udp_tx_gmii. Accepts a byte stream with end-of-packet

---
 rtl/udp_pkt_pkg.sv | 17 +
 rtl/udp_tx_pkt_buffer_if.sv | 10 +
 rtl/sdp_ram.sv | 22 ++
 rtl/udp_tx_pkt_buffer.sv | 184 ++++++++++++++++++
 tb/tb_udp_tx_pkt_buffer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkt_pkg.sv
// Shared types and constants for the UDP TX packet buffer.
package udp_pkt_pkg;

  localparam int unsigned LenW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSend,
    StAbort
  } tx_state_e;

  function automatic logic [LenW-1:0] sat_inc(input logic [LenW-1:0] v);
    return (&v) ? v : v + LenW'(1);
  endfunction

endpackage

// File: rtl/udp_tx_pkt_buffer_if.sv
// Byte-stream ingress handshake for the UDP TX packet buffer.
interface udp_tx_pkt_buffer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
module sdp_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 8
) (
  input  logic          clk_125m,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_125m) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/udp_tx_pkt_buffer.sv
// Store-and-forward packet queue feeding eth_udp_tx_gmii: commits whole packets, then
// announces each with tx_en_pulse/data_len and serves payload bytes on payload_req_i.
module udp_tx_pkt_buffer
  import udp_pkt_pkg::*;
#(
  parameter int unsigned DATA_AW = 11,
  parameter int unsigned LEN_AW  = 3,
  parameter int unsigned MAX_LEN = 1472,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                clk_125m,
  input  logic                rst_n,
  udp_tx_pkt_buffer_if.slave  s,
  output logic                tx_en_pulse,
  output logic [LenW-1:0]     data_len,
  input  logic                tx_done,
  input  logic                payload_req_i,
  output logic [7:0]          payload_dat_o,
  output logic [LEN_AW:0]     pkt_pending,
  output logic [LenW-1:0]     drop_cnt,
  output logic                timeout_err
);

  localparam int unsigned PW  = DATA_AW + 1;
  localparam int unsigned LqW = LEN_AW + 1;
  localparam int unsigned LqD = 2 ** LEN_AW;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   cwr_ptr_q, cwr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LenW-1:0] wlen_q, wlen_d, wlen_inc;
  logic            dropping_q, dropping_d;
  logic [LenW-1:0] drop_cnt_q, drop_cnt_d;

  logic [LenW-1:0] len_mem_q [LqD];
  logic [LqW-1:0]  lwr_q, lrd_q;
  logic            len_full, len_empty, len_push, len_pop;

  tx_state_e       state_q, state_d;
  logic [LenW-1:0] byte_cnt_q, byte_cnt_d;
  logic [LenW-1:0] data_len_q, data_len_d;
  logic [31:0]     timer_q, timer_d;

  logic            ram_full, ram_we, accept;
  logic [7:0]      ram_rdata;

  assign len_full  = (lwr_q ^ lrd_q) == {1'b1, {LEN_AW{1'b0}}};
  assign len_empty = (lwr_q == lrd_q);
  assign ram_full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {DATA_AW{1'b0}}};
  assign s.s_ready = ~len_full;
  assign accept    = s.s_valid & s.s_ready;
  assign wlen_inc  = wlen_q + LenW'(1);

  // Ingress: store bytes, commit on s_last, or rewind and discard the rest of the packet.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cwr_ptr_d  = cwr_ptr_q;
    wlen_d     = wlen_q;
    dropping_d = dropping_q;
    drop_cnt_d = drop_cnt_q;
    ram_we     = 1'b0;
    len_push   = 1'b0;
    if (accept) begin
      if (dropping_q) begin
        if (s.s_last) dropping_d = 1'b0;
      end else if (ram_full || (wlen_inc > LenW'(MAX_LEN))) begin
        wr_ptr_d   = cwr_ptr_q;
        wlen_d     = '0;
        dropping_d = ~s.s_last;
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (s.s_last) begin
          len_push  = 1'b1;
          cwr_ptr_d = wr_ptr_q + PW'(1);
          wlen_d    = '0;
        end else begin
          wlen_d = wlen_inc;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    data_len_d  = data_len_q;
    timer_d     = timer_q;
    len_pop     = 1'b0;
    tx_en_pulse = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!len_empty) begin
          data_len_d = len_mem_q[lrd_q[LEN_AW-1:0]];
          state_d    = StStart;
        end
      end
      StStart: begin
        tx_en_pulse = 1'b1;
        len_pop     = 1'b1;
        byte_cnt_d  = data_len_q;
        timer_d     = 32'd1;
        state_d     = StSend;
      end
      StSend: begin
        timer_d = timer_q + 32'd1;
        if (payload_req_i && (byte_cnt_q != '0)) begin
          rd_ptr_d   = rd_ptr_q + PW'(1);
          byte_cnt_d = byte_cnt_q - LenW'(1);
        end
        if (tx_done) begin
          // Skip anything the TX side left unread so the next packet starts aligned.
          rd_ptr_d   = rd_ptr_q + PW'(byte_cnt_q);
          byte_cnt_d = '0;
          state_d    = StIdle;
        end else if (timer_q >= 32'(TIMEOUT - 1)) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        rd_ptr_d    = rd_ptr_q + PW'(byte_cnt_q);
        byte_cnt_d  = '0;
        timeout_err = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      cwr_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      wlen_q     <= '0;
      dropping_q <= 1'b0;
      drop_cnt_q <= '0;
      lwr_q      <= '0;
      lrd_q      <= '0;
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      data_len_q <= '0;
      timer_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cwr_ptr_q  <= cwr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wlen_q     <= wlen_d;
      dropping_q <= dropping_d;
      drop_cnt_q <= drop_cnt_d;
      if (len_push) lwr_q <= lwr_q + LqW'(1);
      if (len_pop)  lrd_q <= lrd_q + LqW'(1);
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      data_len_q <= data_len_d;
      timer_q    <= timer_d;
    end
  end

  always_ff @(posedge clk_125m) begin
    if (len_push) len_mem_q[lwr_q[LEN_AW-1:0]] <= wlen_inc;
  end

  sdp_ram #(
    .AW(DATA_AW),
    .DW(8)
  ) u_ram (
    .clk_125m(clk_125m),
    .we      (ram_we),
    .waddr   (wr_ptr_q[DATA_AW-1:0]),
    .wdata   (s.s_data),
    .raddr   (rd_ptr_q[DATA_AW-1:0]),
    .rdata   (ram_rdata)
  );

  assign payload_dat_o = ((state_q == StSend) && (byte_cnt_q != '0)) ? ram_rdata : 8'h00;
  assign data_len      = data_len_q;
  assign pkt_pending   = lwr_q - lrd_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_udp_tx_pkt_buffer.sv
// Directed bench for udp_tx_pkt_buffer: vector table for the main flow plus hand sequences.
module tb_udp_tx_pkt_buffer;

  logic clk_125m = 1'b0;
  logic rst_n    = 1'b0;
  always #4 clk_125m = ~clk_125m;

  int cyc = 0;
  always @(posedge clk_125m) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Main instance: default parameters.
  udp_tx_pkt_buffer_if s_if ();
  logic        tx_en_pulse, tx_done, payload_req, timeout_err;
  logic [15:0] data_len, drop_cnt;
  logic [7:0]  payload_dat;
  logic [3:0]  pkt_pending;

  udp_tx_pkt_buffer dut (
    .clk_125m     (clk_125m),
    .rst_n        (rst_n),
    .s            (s_if),
    .tx_en_pulse  (tx_en_pulse),
    .data_len     (data_len),
    .tx_done      (tx_done),
    .payload_req_i(payload_req),
    .payload_dat_o(payload_dat),
    .pkt_pending  (pkt_pending),
    .drop_cnt     (drop_cnt),
    .timeout_err  (timeout_err)
  );

  // Second instance: short timeout.
  udp_tx_pkt_buffer_if s_if2 ();
  logic        tx_en2, tx_done2, req2, terr2;
  logic [15:0] data_len2, drop2;
  logic [7:0]  dat2;
  logic [2:0]  pend2;

  udp_tx_pkt_buffer #(
    .DATA_AW(6),
    .LEN_AW (2),
    .MAX_LEN(60),
    .TIMEOUT(100)
  ) dut2 (
    .clk_125m     (clk_125m),
    .rst_n        (rst_n),
    .s            (s_if2),
    .tx_en_pulse  (tx_en2),
    .data_len     (data_len2),
    .tx_done      (tx_done2),
    .payload_req_i(req2),
    .payload_dat_o(dat2),
    .pkt_pending  (pend2),
    .drop_cnt     (drop2),
    .timeout_err  (terr2)
  );

  string hello_s = "Hello, welcome to FPGA!";

  logic [7:0] exp_bytes [$];
  int         exp_lens  [$];
  logic [15:0] ev_len   [$];
  logic [15:0] ev2_len  [$];
  int          ev2_cyc  [$];

  always @(negedge clk_125m) begin
    if (tx_en_pulse === 1'b1) ev_len.push_back(data_len);
    if (tx_en2 === 1'b1) begin
      ev2_len.push_back(data_len2);
      ev2_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
    return seed + 8'(i * 13) + 8'(i >> 8);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic write_pkt(input int len, input logic [7:0] seed, input bit hello,
                           input bit commit);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = hello ? 8'(hello_s[i]) : pat(seed, i);
      @(negedge clk_125m);
      s_if.s_valid = 1'b1;
      s_if.s_data  = b;
      s_if.s_last  = (i == len - 1);
      #1;
      for (int g = 0; g < 1000 && !s_if.s_ready; g++) @(negedge clk_125m);
      if (commit) exp_bytes.push_back(b);
    end
    @(negedge clk_125m);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    if (commit) exp_lens.push_back(len);
  endtask

  task automatic write_pkt2(input int len, input logic [7:0] seed);
    for (int i = 0; i < len; i++) begin
      @(negedge clk_125m);
      s_if2.s_valid = 1'b1;
      s_if2.s_data  = pat(seed, i);
      s_if2.s_last  = (i == len - 1);
    end
    @(negedge clk_125m);
    s_if2.s_valid = 1'b0;
    s_if2.s_last  = 1'b0;
  endtask

  // Waits for the next announced packet, drains it with payload_req and closes with tx_done.
  task automatic sink_one(input string name);
    int         len, g, bad_idx;
    logic [7:0] got, exp, bad_got, bad_exp;
    len = exp_lens.pop_front();
    g = 0;
    while (ev_len.size() == 0 && g < 300) begin
      @(negedge clk_125m);
      g++;
    end
    if (ev_len.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s start: no tx_en_pulse within %0d cycles, expected len %0d", name, g, len);
      for (int i = 0; i < len; i++) void'(exp_bytes.pop_front());
      return;
    end
    check({name, " data_len at pulse"}, 32'(ev_len.pop_front()), 32'(len));
    @(negedge clk_125m);
    payload_req = 1'b1;
    bad_idx = -1;
    bad_got = 8'h00;
    bad_exp = 8'h00;
    for (int i = 0; i < len + 2; i++) begin
      #1;
      got = payload_dat;
      exp = (i < len) ? exp_bytes.pop_front() : 8'h00;
      if (got !== exp && bad_idx < 0) begin
        bad_idx = i;
        bad_got = got;
        bad_exp = exp;
      end
      @(negedge clk_125m);
    end
    payload_req = 1'b0;
    n_cmp++;
    if (bad_idx >= 0) begin
      n_bad++;
      $display("FAIL %s payload: byte %0d got 0x%02h expected 0x%02h", name, bad_idx, bad_got,
               bad_exp);
    end
    check({name, " data_len hold"}, 32'(data_len), 32'(len));
    tx_done = 1'b1;
    @(negedge clk_125m);
    tx_done = 1'b0;
  endtask

  typedef struct {
    int         len;
    logic [7:0] seed;
    bit         hello;
    bit         commit;
    int         exp_pend;
    int         exp_drop;
    bit         drain;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t0, t1;
    logic [15:0] l2;

    vecs[0] = '{23,   8'h00, 1'b1, 1'b1, 0, 0, 1'b0};
    vecs[1] = '{1,    8'h11, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[2] = '{64,   8'h22, 1'b0, 1'b1, 2, 0, 1'b0};
    vecs[3] = '{1472, 8'h33, 1'b0, 1'b1, 3, 0, 1'b1};
    vecs[4] = '{1473, 8'h44, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[5] = '{10,   8'h55, 1'b0, 1'b1, 0, 1, 1'b1};

    s_if.s_valid  = 1'b0; s_if.s_data  = 8'h00; s_if.s_last  = 1'b0;
    s_if2.s_valid = 1'b0; s_if2.s_data = 8'h00; s_if2.s_last = 1'b0;
    tx_done = 1'b0; payload_req = 1'b0;
    tx_done2 = 1'b0; req2 = 1'b0;

    repeat (3) @(negedge clk_125m);
    #1;
    check("reset s_ready", 32'(s_if.s_ready), 32'd1);
    check("reset tx_en_pulse", 32'(tx_en_pulse), 32'd0);
    check("reset data_len", 32'(data_len), 32'd0);
    check("reset payload_dat", 32'(payload_dat), 32'd0);
    check("reset pkt_pending", 32'(pkt_pending), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // Hello, back-to-back 1/64/1472 with pending peak, oversize drop then a 10 B packet.
    for (int v = 0; v < 6; v++) begin
      write_pkt(vecs[v].len, vecs[v].seed, vecs[v].hello, vecs[v].commit);
      repeat (4) @(negedge clk_125m);
      check($sformatf("vec%0d pkt_pending", v), 32'(pkt_pending), 32'(vecs[v].exp_pend));
      check($sformatf("vec%0d drop_cnt", v), 32'(drop_cnt), 32'(vecs[v].exp_drop));
      if (vecs[v].drain) begin
        while (exp_lens.size() > 0) sink_one($sformatf("vec%0d drain", v));
        repeat (4) @(negedge clk_125m);
        check($sformatf("vec%0d pending after drain", v), 32'(pkt_pending), 32'd0);
      end
    end

    // RAM overflow mid-packet while the TX side stalls; the rewind must leave room for D.
    write_pkt(1000, 8'h61, 1'b0, 1'b1);
    write_pkt(1000, 8'h62, 1'b0, 1'b1);
    write_pkt(100, 8'h63, 1'b0, 1'b0);
    repeat (2) @(negedge clk_125m);
    check("overflow drop_cnt", 32'(drop_cnt), 32'd2);
    check("overflow pkt_pending", 32'(pkt_pending), 32'd1);
    write_pkt(40, 8'h64, 1'b0, 1'b1);
    repeat (2) @(negedge clk_125m);
    check("after rewind drop_cnt", 32'(drop_cnt), 32'd2);
    check("after rewind pkt_pending", 32'(pkt_pending), 32'd2);
    while (exp_lens.size() > 0) sink_one("overflow drain");
    repeat (4) @(negedge clk_125m);
    check("overflow pending end", 32'(pkt_pending), 32'd0);

    // Timeout: take one byte of P, withhold tx_done, then Q must start from its own first byte.
    write_pkt2(3, 8'h50);
    write_pkt2(4, 8'hA0);
    for (int g = 0; g < 300 && ev2_len.size() == 0; g++) @(negedge clk_125m);
    if (ev2_len.size() == 0) begin
      $display("FAIL timeout start: no tx_en_pulse on short-timeout instance");
      $fatal(1, "no start");
    end
    t0 = ev2_cyc.pop_front();
    l2 = ev2_len.pop_front();
    check("timeout P data_len", 32'(l2), 32'd3);
    @(negedge clk_125m);
    req2 = 1'b1;
    #1;
    check("timeout P byte0", 32'(dat2), 32'(pat(8'h50, 0)));
    @(negedge clk_125m);
    req2 = 1'b0;
    t1 = -1;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk_125m);
      if (terr2 === 1'b1) begin
        t1 = cyc;
        break;
      end
    end
    check("timeout delay", 32'(t1 - t0), 32'd100);
    @(negedge clk_125m);
    check("timeout_err one cycle", 32'(terr2), 32'd0);
    for (int g = 0; g < 50 && ev2_len.size() == 0; g++) @(negedge clk_125m);
    l2 = (ev2_len.size() > 0) ? ev2_len.pop_front() : 16'hFFFF;
    check("timeout Q data_len", 32'(l2), 32'd4);
    @(negedge clk_125m);
    req2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("timeout Q byte%0d", i), 32'(dat2), 32'(pat(8'hA0, i)));
      @(negedge clk_125m);
    end
    req2 = 1'b0;
    tx_done2 = 1'b1;
    @(negedge clk_125m);
    tx_done2 = 1'b0;
    repeat (3) @(negedge clk_125m);
    check("timeout pend2 end", 32'(pend2), 32'd0);

    // Reset in the middle of a send flushes everything; the next packet must go out cleanly.
    write_pkt(20, 8'h70, 1'b0, 1'b0);
    write_pkt(5, 8'h71, 1'b0, 1'b0);
    repeat (2) @(negedge clk_125m);
    check("pre-reset pkt_pending", 32'(pkt_pending), 32'd1);
    @(negedge clk_125m);
    payload_req = 1'b1;
    repeat (5) @(negedge clk_125m);
    payload_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midsend reset s_ready", 32'(s_if.s_ready), 32'd1);
    check("midsend reset tx_en_pulse", 32'(tx_en_pulse), 32'd0);
    check("midsend reset data_len", 32'(data_len), 32'd0);
    check("midsend reset payload_dat", 32'(payload_dat), 32'd0);
    check("midsend reset pkt_pending", 32'(pkt_pending), 32'd0);
    check("midsend reset drop_cnt", 32'(drop_cnt), 32'd0);
    check("midsend reset timeout_err", 32'(timeout_err), 32'd0);
    ev_len.delete();
    exp_lens.delete();
    exp_bytes.delete();
    @(negedge clk_125m);
    rst_n = 1'b1;
    write_pkt(12, 8'h72, 1'b0, 1'b1);
    sink_one("post-reset");
    repeat (4) @(negedge clk_125m);
    check("post-reset pkt_pending", 32'(pkt_pending), 32'd0);
    check("post-reset drop_cnt", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
